// File: rtl/seq_pkg.sv
// seq_pkg -- shared definitions for the seq_pc_stack program sequencer.
//   op_e        : sequencing operation encoding (codes 5-7 decode as STEP)
//   DEF_*       : default counter/page/stack sizes
//   lfsr_next   : one polynomial-counter step, width and tap given as args
package seq_pkg;

  typedef enum logic [2:0] {
    OP_STEP = 3'd0,
    OP_JMP  = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_LDPG = 3'd4
  } op_e;

  localparam int DEF_PL_W      = 6;
  localparam int DEF_PU_W      = 4;
  localparam int DEF_STK_DEPTH = 5;

  // Shift right, feed XNOR(v[0], v[tap]) into the MSB. The all-ones state
  // is a fixed point and is intentionally left uncorrected. Bits above
  // w-1 must be zero on entry; callers truncate the result to w bits.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v,
                                            input int unsigned w,
                                            input int unsigned tap);
    logic [31:0] r;
    r = v >> 1;
    r[5'(w - 1)] = ~(v[0] ^ v[5'(tap)]);
    return r;
  endfunction

endpackage

// File: rtl/seq_pc_stack_if.sv
// seq_pc_stack_if -- operation/status bundle of the program sequencer.
//   en, op, tgt, page_in          : operation request (master -> slave)
//   pc, depth, stk_full,
//   stk_empty, pg_pending         : sequencer state (slave -> master)
//   ovf, unf                      : sticky stack faults, only when
//                                   SEQ_STACK_GUARD_EN is defined
interface seq_pc_stack_if
  import seq_pkg::*;
#(
  parameter int PL_W      = DEF_PL_W,
  parameter int PU_W      = DEF_PU_W,
  parameter int STK_DEPTH = DEF_STK_DEPTH
);
  localparam int DW = $clog2(STK_DEPTH + 1);

  logic                 en;
  logic [2:0]           op;
  logic [PL_W-1:0]      tgt;
  logic [PU_W-1:0]      page_in;
  logic [PU_W+PL_W-1:0] pc;
  logic [DW-1:0]        depth;
  logic                 stk_full;
  logic                 stk_empty;
  logic                 pg_pending;
`ifdef SEQ_STACK_GUARD_EN
  logic                 ovf;
  logic                 unf;

  modport master (output en, op, tgt, page_in,
                  input  pc, depth, stk_full, stk_empty, pg_pending, ovf, unf);
  modport slave  (input  en, op, tgt, page_in,
                  output pc, depth, stk_full, stk_empty, pg_pending, ovf, unf);
`else
  modport master (output en, op, tgt, page_in,
                  input  pc, depth, stk_full, stk_empty, pg_pending);
  modport slave  (input  en, op, tgt, page_in,
                  output pc, depth, stk_full, stk_empty, pg_pending);
`endif

endinterface

// File: rtl/seq_ret_stack.sv
// seq_ret_stack -- shift-register return-address stack, top at index 0.
//   clk, rst : clock, synchronous active-high reset (clears entries)
//   push     : shift down, din enters at the top; oldest falls off when full
//   pop      : shift up; the bottom entry keeps its value
//   din, top : data in / current top entry
//   depth    : valid entry count, saturating at 0 and DEPTH
//   full     : depth == DEPTH
//   empty    : depth == 0
// push has priority if both strobes are high.
module seq_ret_stack #(
  parameter int W     = 10,
  parameter int DEPTH = 5,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [DW-1:0]           depth_q;

  assign full  = (depth_q == DW'(DEPTH));
  assign empty = (depth_q == '0);
  assign depth = depth_q;
  // Entries at or below the valid depth always equal the bottom entry
  // (reset clears all, pops duplicate the bottom upward), so when empty
  // the top already holds the stale bottom value.
  assign top   = mem_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      depth_q <= '0;
    end else if (push) begin
      mem_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
      if (!full) depth_q <= depth_q + 1'b1;
    end else if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
      if (!empty) depth_q <= depth_q - 1'b1;
    end
  end

endmodule

// File: rtl/seq_pc_stack.sv
// seq_pc_stack -- program sequencer: page/polynomial PC plus return stack.
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active high, overrides en
//   bus  : seq_pc_stack_if.slave (en/op/tgt/page_in in; pc/depth/
//          stk_full/stk_empty/pg_pending out; ovf/unf under guard)
// Optional: define SEQ_STACK_GUARD_EN for sticky ovf/unf flags; a RET on an
// empty stack then loads RST_PC instead of the stale bottom entry.
module seq_pc_stack
  import seq_pkg::*;
#(
  parameter int                   PL_W      = DEF_PL_W,
  parameter int                   PU_W      = DEF_PU_W,
  parameter int                   TAP       = 1,
  parameter int                   STK_DEPTH = DEF_STK_DEPTH,
  parameter logic [PU_W-1:0]      CALL_PAGE = '1,
  parameter logic [PU_W+PL_W-1:0] RST_PC    = '0
) (
  input  logic           clk,
  input  logic           rst,
  seq_pc_stack_if.slave  bus
);

  localparam int DW = $clog2(STK_DEPTH + 1);
  localparam int AW = PU_W + PL_W;

  logic [PU_W-1:0] pu_q, page_q;
  logic [PL_W-1:0] pl_q, pl_nxt;
  logic            pend_q;
  logic            push, pop;
  logic [AW-1:0]   stk_top;
  logic [DW-1:0]   stk_depth;
  logic            stk_full, stk_empty;

  assign pl_nxt = PL_W'(lfsr_next(32'(pl_q), PL_W, TAP));

  // Stack strobes are gated here; the stack's own reset wins over them.
  assign push = bus.en && (bus.op == OP_CALL);
  assign pop  = bus.en && (bus.op == OP_RET);

  seq_ret_stack #(.W(AW), .DEPTH(STK_DEPTH)) u_stk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({pu_q, pl_nxt}),  // return to the next sequential address
    .top   (stk_top),
    .depth (stk_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

`ifdef SEQ_STACK_GUARD_EN
  logic ovf_q, unf_q;
  assign bus.ovf = ovf_q;
  assign bus.unf = unf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      {pu_q, pl_q} <= RST_PC;
      page_q       <= '0;
      pend_q       <= 1'b0;
`ifdef SEQ_STACK_GUARD_EN
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
`endif
    end else if (bus.en) begin
      case (bus.op)
        OP_JMP: begin
          pl_q   <= bus.tgt;
          if (pend_q) pu_q <= page_q;
          pend_q <= 1'b0;
        end
        OP_CALL: begin
          pl_q   <= bus.tgt;
          pu_q   <= pend_q ? page_q : CALL_PAGE;
          pend_q <= 1'b0;
`ifdef SEQ_STACK_GUARD_EN
          if (stk_full) ovf_q <= 1'b1;
`endif
        end
        OP_RET: begin
`ifdef SEQ_STACK_GUARD_EN
          if (stk_empty) begin
            {pu_q, pl_q} <= RST_PC;
            unf_q        <= 1'b1;
          end else begin
            {pu_q, pl_q} <= stk_top;
          end
`else
          {pu_q, pl_q} <= stk_top;
`endif
        end
        OP_LDPG: begin
          // First preload wins until a JMP/CALL consumes it.
          if (!pend_q) begin
            page_q <= bus.page_in;
            pend_q <= 1'b1;
          end
          pl_q <= pl_nxt;
        end
        default: pl_q <= pl_nxt;  // STEP and undefined codes
      endcase
    end
  end

  assign bus.pc         = {pu_q, pl_q};
  assign bus.depth      = stk_depth;
  assign bus.stk_full   = stk_full;
  assign bus.stk_empty  = stk_empty;
  assign bus.pg_pending = pend_q;

endmodule
